// File: rtl/fracn_mmd_divider_pkg.sv
// Shared types and helpers for the fractional-N divider and the MASH offset path.
// dn is a small two's-complement offset; only -1..+2 are produced by a MASH 1-1.
package fracn_mmd_divider_pkg;

  localparam int DN_W = 3;

  typedef logic signed [DN_W-1:0] dn_t;

  function automatic logic dn_legal(input dn_t d);
    logic w_ok;
    case (d)
      3'sb000, 3'sb001, 3'sb010, 3'sb111: w_ok = 1'b1;
      default:                            w_ok = 1'b0;
    endcase
    return w_ok;
  endfunction

  function automatic int sext_dn(input dn_t d);
    return int'(d);
  endfunction

endpackage

// File: rtl/fracn_mmd_divider_ratio_calc.sv
// Combinational divide-ratio calculation: n_int + sign-extended dn, clamped to
// [MIN_DIV, 2^NBITS-1]. Illegal dn codes contribute zero and raise the clamp flag.
module fracn_ratio_calc
  import fracn_mmd_divider_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int MIN_DIV = 4
) (
  input  logic [NBITS-1:0] i_n_int,
  input  dn_t              i_dn,
  output logic [NBITS-1:0] o_ratio,
  output logic             o_clamp
);

  localparam int RW = NBITS + 2;
  localparam logic signed [RW-1:0] RMIN = RW'(MIN_DIV);
  localparam logic signed [RW-1:0] RMAX = RW'((2 ** NBITS) - 1);

  logic                 w_legal;
  logic signed [RW-1:0] w_dn_ext;
  logic signed [RW-1:0] w_sum;

  // Sign-extend, add and saturate in a two-bit-wider signed domain.
  always_comb begin
    w_legal  = dn_legal(i_dn);
    w_dn_ext = w_legal ? RW'(sext_dn(i_dn)) : '0;
    w_sum    = $signed({2'b00, i_n_int}) + w_dn_ext;
    o_clamp  = ~w_legal;
    if (w_sum < RMIN) begin
      o_ratio = RMIN[NBITS-1:0];
      o_clamp = 1'b1;
    end else if (w_sum > RMAX) begin
      o_ratio = RMAX[NBITS-1:0];
      o_clamp = 1'b1;
    end else begin
      o_ratio = w_sum[NBITS-1:0];
    end
  end

endmodule

// File: rtl/fracn_mmd_divider.sv
// Fractional-N multi-modulus divider: each output period lasts R = n_int + dn input
// clocks, marked by a one-cycle div_pulse and a near-50% registered div_clk.
module fracn_mmd_divider
  import fracn_mmd_divider_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int MIN_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [NBITS-1:0] i_n_int,
  input  logic [DN_W-1:0]  i_dn,
  output logic             o_div_pulse,
  output logic             o_div_clk,
  output logic [NBITS-1:0] o_ratio,
  output logic             o_clamped
);

  localparam logic [NBITS-1:0] ONE = NBITS'(1);

  logic [NBITS-1:0] r_cnt;
  logic [NBITS-1:0] r_ratio;
  logic             r_div_pulse;
  logic             r_div_clk;
  logic             r_clamped;

  logic [NBITS-1:0] w_calc_ratio;
  logic             w_calc_clamp;
  logic [NBITS-1:0] w_cnt_nxt;
  logic [NBITS-1:0] w_ratio_nxt;
  logic             w_pulse_nxt;
  logic             w_dclk_nxt;
  logic             w_clamped_nxt;

  fracn_ratio_calc #(
    .NBITS   (NBITS),
    .MIN_DIV (MIN_DIV)
  ) u_ratio_calc (
    .i_n_int (i_n_int),
    .i_dn    ($signed(i_dn)),
    .o_ratio (w_calc_ratio),
    .o_clamp (w_calc_clamp)
  );

  // Reload on terminal count, otherwise count down; everything holds while disabled.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_ratio_nxt   = r_ratio;
    w_pulse_nxt   = 1'b0;
    w_dclk_nxt    = 1'b0;
    w_clamped_nxt = r_clamped;
    if (i_en) begin
      if (r_cnt == '0) begin
        w_cnt_nxt     = w_calc_ratio - ONE;
        w_ratio_nxt   = w_calc_ratio;
        w_pulse_nxt   = 1'b1;
        w_clamped_nxt = r_clamped | w_calc_clamp;
      end else begin
        w_cnt_nxt     = r_cnt - ONE;
      end
      // Upper half of the count range is the high phase: ceil(R/2) cycles.
      w_dclk_nxt = (w_cnt_nxt >= (w_ratio_nxt >> 1));
    end else begin
      w_dclk_nxt = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_ratio     <= NBITS'(MIN_DIV);
      r_div_pulse <= 1'b0;
      r_div_clk   <= 1'b0;
      r_clamped   <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_ratio     <= w_ratio_nxt;
      r_div_pulse <= w_pulse_nxt;
      r_div_clk   <= w_dclk_nxt;
      r_clamped   <= w_clamped_nxt;
    end
  end

  assign o_div_pulse = r_div_pulse;
  assign o_div_clk   = r_div_clk;
  assign o_ratio     = r_ratio;
  assign o_clamped   = r_clamped;

endmodule

// File: tb/tb_fracn_mmd_divider.sv
// Self-checking bench for fracn_mmd_divider: phase-based behavioural model compared
// every cycle, directed period/duty measurements, and a closed MASH 1-1 loop.
module tb_fracn_mmd_divider;

  localparam int NBITS   = 8;
  localparam int MIN_DIV = 4;
  localparam int MAXR    = (1 << NBITS) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [NBITS-1:0] n_int;
  logic [2:0]       dn;
  logic             div_pulse;
  logic             div_clk;
  logic [NBITS-1:0] ratio;
  logic             clamped;

  fracn_mmd_divider #(.NBITS(NBITS), .MIN_DIV(MIN_DIV)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_n_int     (n_int),
    .i_dn        (dn),
    .o_div_pulse (div_pulse),
    .o_div_clk   (div_clk),
    .o_ratio     (ratio),
    .o_clamped   (clamped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference ratio straight from the arithmetic rules.
  task automatic ref_ratio(input int n, input logic [2:0] d, output int r, output bit cl);
    int off;
    cl = 1'b0;
    case (d)
      3'd0:    off = 0;
      3'd1:    off = 1;
      3'd2:    off = 2;
      3'd7:    off = -1;
      default: begin off = 0; cl = 1'b1; end
    endcase
    r = n + off;
    if (r < MIN_DIV) begin
      r = MIN_DIV; cl = 1'b1;
    end else if (r > MAXR) begin
      r = MAXR; cl = 1'b1;
    end
  endtask

  // Model: position inside the current period (0..R-1) and the period length.
  bit m_active;
  int m_phase, m_len;
  int exp_pulse, exp_dclk, exp_ratio, exp_clamped;

  task automatic model_reset();
    m_active = 1'b0; m_phase = 0; m_len = MIN_DIV;
    exp_pulse = 0; exp_dclk = 0; exp_ratio = MIN_DIV; exp_clamped = 0;
  endtask

  task automatic model_step();
    int r; bit cl;
    if (rst) begin
      model_reset();
    end else if (!en) begin
      exp_pulse = 0; exp_dclk = 0;
    end else if (!m_active || m_phase == m_len - 1) begin
      ref_ratio(int'(n_int), dn, r, cl);
      m_active = 1'b1; m_phase = 0; m_len = r;
      exp_ratio = r; exp_pulse = 1; exp_dclk = 1;
      if (cl) exp_clamped = 1;
    end else begin
      m_phase++;
      exp_pulse = 0;
      exp_dclk = (m_phase < (m_len + 1) / 2) ? 1 : 0;
    end
  endtask

  always @(negedge clk) begin
    chk("div_pulse", int'(div_pulse), exp_pulse);
    chk("div_clk", int'(div_clk), exp_dclk);
    chk("ratio", int'(ratio), exp_ratio);
    chk("clamped", int'(clamped), exp_clamped);
  end

  // Period/duty measurement between successive div_pulse cycles.
  bit seen = 1'b0;
  int cyc_since = 0, high_cnt = 0, meas_period = 0, meas_high = 0, off_pulses = 0;

  always @(negedge clk) begin
    if (!en && div_pulse) off_pulses++;
    if (rst) begin
      seen = 1'b0; cyc_since = 0; high_cnt = 0;
    end else if (div_pulse) begin
      if (seen) begin
        meas_period = cyc_since; meas_high = high_cnt;
      end
      seen = 1'b1; cyc_since = 1; high_cnt = int'(div_clk);
    end else begin
      cyc_since++; high_cnt += int'(div_clk);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_pulses(input int k, input int limit);
    int got = 0;
    for (int c = 0; c < limit && got < k; c++) begin
      tick();
      if (div_pulse) got++;
    end
    chk("pulse_wait", got, k);
  endtask

  task automatic async_reset();
    @(posedge clk);
    model_step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_pulse", int'(div_pulse), 0);
    chk("rst_dclk", int'(div_clk), 0);
    chk("rst_ratio", int'(ratio), 4);
    chk("rst_clamped", int'(clamped), 0);
    @(negedge clk);
    #1;
    tick();
    rst = 1'b0;
  endtask

  int acc1, acc2, c2d;

  task automatic mash_step();
    int c1, c2, d;
    acc1 += 64;  c1 = (acc1 >= 256) ? 1 : 0; acc1 %= 256;
    acc2 += acc1; c2 = (acc2 >= 256) ? 1 : 0; acc2 %= 256;
    d = c1 + c2 - c2d;
    c2d = c2;
    dn = d[2:0];
  endtask

  initial begin
    int sum, npulse, rmin, rmax;
    model_reset();
    rst = 1'b1; en = 1'b0; n_int = 8'd8; dn = 3'd0;
    repeat (2) tick();
    rst = 1'b0;

    en = 1'b1;
    run_pulses(4, 100);
    chk("t1_period", meas_period, 8);
    chk("t1_high", meas_high, 4);
    chk("t1_ratio", int'(ratio), 8);
    chk("t1_clamped", int'(clamped), 0);

    dn = 3'b111;
    run_pulses(3, 100);
    chk("t2a_period", meas_period, 7);
    chk("t2a_high", meas_high, 4);
    dn = 3'b010;
    run_pulses(3, 100);
    chk("t2b_period", meas_period, 10);
    chk("t2b_high", meas_high, 5);
    chk("t2_clamped", int'(clamped), 0);

    n_int = 8'd3; dn = 3'b111;
    run_pulses(2, 100);
    chk("t3a_ratio", int'(ratio), 4);
    chk("t3a_period", meas_period, 4);
    chk("t3a_clamped", int'(clamped), 1);
    n_int = 8'd255; dn = 3'b010;
    run_pulses(2, 1000);
    chk("t3b_ratio", int'(ratio), 255);
    chk("t3b_period", meas_period, 255);
    chk("t3b_high", meas_high, 128);

    async_reset();
    n_int = 8'd9; dn = 3'b100;
    run_pulses(2, 100);
    chk("t4_ratio", int'(ratio), 9);
    chk("t4_period", meas_period, 9);
    chk("t4_clamped", int'(clamped), 1);
    repeat (3) tick();
    dn = 3'b010;
    run_pulses(1, 100);
    chk("t4_dn_midperiod", meas_period, 9);
    chk("t4_new_ratio", int'(ratio), 11);

    n_int = 8'd12; dn = 3'b000;
    run_pulses(2, 100);
    repeat (4) tick();
    en = 1'b0; off_pulses = 0;
    repeat (5) tick();
    en = 1'b1;
    run_pulses(1, 100);
    chk("t5_spacing", meas_period, 17);
    chk("t5_off_pulses", off_pulses, 0);

    async_reset();
    n_int = 8'd10; acc1 = 0; acc2 = 0; c2d = 0; dn = 3'd0;
    sum = 0; npulse = 0; rmin = 1000; rmax = 0;
    for (int c = 0; c < 4000 && npulse < 256; c++) begin
      tick();
      if (div_pulse) begin
        sum += int'(ratio); npulse++;
        if (int'(ratio) < rmin) rmin = int'(ratio);
        if (int'(ratio) > rmax) rmax = int'(ratio);
        mash_step();
      end
    end
    chk("t6_periods", npulse, 256);
    chk("t6_ratio_sum", sum, 2624);
    chk("t6_ratio_range", (rmin >= 9 && rmax <= 12) ? 1 : 0, 1);
    for (int c = 0; c < 47; c++) begin
      tick();
      if (div_pulse) mash_step();
    end
    async_reset();
    tick();
    chk("t6_restart_pulse", int'(div_pulse), 1);

    for (int c = 0; c < 2500; c++) begin
      en = ($urandom_range(9) != 0);
      n_int = ($urandom_range(7) == 0) ? 8'(250 + $urandom_range(5)) : 8'($urandom_range(23));
      dn = 3'($urandom_range(7));
      if ($urandom_range(299) == 0) async_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
